sdr_apb_master: RTL and testbench
=================================

SDR_APB_MASTER -- requirements
Module: sdr_apb_master

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clock port pclk, reset port preset.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: number of ACCESS cycles without pready before a transfer aborts.
REQ-003 Parameter ADDR_W, default 16: APB address width.
REQ-004 Parameter DATA_W, default 16: APB data width.
REQ-005 The ports SHALL be as follows:
- pclk  in  1  clock, all logic on rising edge
- preset  in  1  synchronous active-high reset
- req_valid  in  1  user command valid
- req_ready  out  1  command accepted when req_valid and req_ready are both high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  command address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  direction of the completed command
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  completion was a timeout
- busy  out  1  state is not IDLE
- txn_count  out  16  completed transfers, wrapping
- err_count  out  8  timeouts, saturating at 255
- pselect  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB completion

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-007 In IDLE: pselect=0, penable=0, and paddr/pwdata/pwrite=0; req_ready=1.
REQ-008 In IDLE, on req_valid at a rising edge, the block SHALL latch req_write/req_addr/req_wdata and go to SETUP.
REQ-009 SETUP SHALL last exactly one cycle (pselect=1, penable=0, req_ready=0) and then go to ACCESS.
REQ-010 In ACCESS (pselect=1, penable=1), pwrite/paddr/pwdata SHALL be held stable from SETUP until exit.
REQ-011 When pready is sampled high in ACCESS, the transfer SHALL complete:
- prdata is captured for reads;
- the next cycle has rsp_valid=1 and rsp_err=0.
REQ-012 In ACCESS, req_ready SHALL equal pready. If req_valid is also high, the next command is latched and the state goes directly to SETUP (back-to-back); otherwise the state goes to IDLE.
REQ-013 Latency SHALL be as follows, for accept at edge k and pready high in the first ACCESS cycle:
- SETUP in cycle k+1;
- ACCESS in cycle k+2;
- rsp_valid in cycle k+3.
REQ-014 The timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready=0.
REQ-015 When the timeout counter reaches TIMEOUT_CYCLES-1 with pready=0, the block SHALL:
- return to IDLE (pselect and penable drop at the next edge);
- pulse rsp_valid with rsp_err=1 and rsp_rdata=0;
- not accept a back-to-back command.
REQ-016 If pready and the timeout condition coincide, pready SHALL win (normal completion).
REQ-017 rsp_valid SHALL have no backpressure, and rsp_* SHALL hold their values until the next completion.
REQ-018 txn_count SHALL increment on every rsp_valid, error or not, and wrap from 0xFFFF to 0.
REQ-019 err_count SHALL increment on every rsp_err and saturate at 255.
REQ-020 rsp_rdata SHALL be 0 for writes.

Reset
REQ-021 While preset is high at a rising edge, the block SHALL:
- enter IDLE;
- set all outputs to 0, including req_ready, counters and rsp_*.
REQ-022 req_ready SHALL rise in the first cycle after preset deasserts.
REQ-023 Reset asserted mid-transfer SHALL drop pselect and penable at that edge, produce no rsp_valid, and discard the latched command.

Structure
REQ-024 The shared package sdr_parameters SHALL hold:
- enum apb_mst_state_t {IDLE, SETUP, ACCESS};
- constant APB_TIMEOUT_DEFAULT=64;
- a state-name function getApbMstStateName for debug display.
REQ-025 The block SHALL be a single module with no sub-module; the timeout counter and stats counters are inline.

Verification
REQ-026 Write: req_write=1, addr=0x0010, wdata=0xA5A5, pready high in the first ACCESS cycle -> paddr=0x0010 and pwdata=0xA5A5 stable for 2 cycles; rsp_valid at k+3 with rsp_err=0; txn_count=1.
REQ-027 Read: addr=0x0020, prdata=0x1234, pready after 3 wait cycles -> rsp_rdata=0x1234 and rsp_write=0; penable high for 4 cycles.
REQ-028 Back-to-back: 4 writes to 0x0000..0x0003, req_valid held high, pready always 1 -> pselect continuous, SETUP and ACCESS alternate, 4 rsp_valid pulses 2 cycles apart.
REQ-029 Timeout: TIMEOUT_CYCLES=8, pready held 0 -> ACCESS lasts 8 cycles, then rsp_err=1 and rsp_rdata=0; err_count=1; busy=0 the next cycle.
REQ-030 Coincidence: pready rises in the 8th ACCESS cycle with TIMEOUT_CYCLES=8 -> rsp_err=0; err_count unchanged.
REQ-031 Reset mid-ACCESS: assert preset for 1 cycle -> pselect=0 at that edge; no rsp_valid; counters 0; req_ready=1 on the next cycle.

Source files
------------

// File: rtl/sdr_parameters.sv
// Shared definitions for the simple APB master.
//   apb_mst_state_t      : IDLE / SETUP / ACCESS phases of one APB transfer
//   APB_TIMEOUT_DEFAULT  : default number of ACCESS cycles before a transfer aborts
//   getApbMstStateName   : readable state name for debug display
package sdr_parameters;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_mst_state_t;

    localparam int APB_TIMEOUT_DEFAULT = 64;

    function automatic string getApbMstStateName(input apb_mst_state_t s);
        case (s)
            IDLE:    return "IDLE";
            SETUP:   return "SETUP";
            ACCESS:  return "ACCESS";
            default: return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/sdr_apb_master.sv
// Single-command APB master with timeout and completion statistics.
// Ports:
//   pclk, preset            clock and synchronous active-high reset
//   req_valid/req_ready     user command handshake
//   req_write/addr/wdata    user command contents
//   rsp_valid               one-cycle completion pulse (no backpressure)
//   rsp_write/rdata/err     completion details, held until the next completion
//   busy                    a transfer is in progress
//   txn_count / err_count   completed transfers (wrapping) / timeouts (saturating)
//   pselect..pwdata         APB request side
//   prdata, pready          APB completion side
module sdr_apb_master
    import sdr_parameters::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [15:0]       txn_count,
    output logic [7:0]        err_count,
    output logic              pselect,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    apb_mst_state_t    state;
    apb_mst_state_t    next_state;
    logic [TMO_W-1:0]  tmo_count;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              accept;
    logic              done_ok;
    logic              done_tmo;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake decode. req_ready is forced low while reset
    // is applied so no command appears accepted during reset.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_tmo   = 1'b0;
        req_ready  = 1'b0;
        pselect    = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !preset;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                pselect    = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                pselect   = 1'b1;
                penable   = 1'b1;
                req_ready = pready && !preset;
                // pready takes priority over an expiring timeout
                if (pready) begin
                    done_ok = 1'b1;
                    if (req_valid) begin
                        accept     = 1'b1;
                        next_state = SETUP;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (tmo_count == TMO_LAST) begin
                    done_tmo   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // APB request fields read as zero whenever no transfer is in flight.
    assign busy   = (state != IDLE);
    assign pwrite = busy ? cmd_write : 1'b0;
    assign paddr  = busy ? cmd_addr  : '0;
    assign pwdata = busy ? cmd_wdata : '0;

    // Command latch, timeout counter, response registers and statistics.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            tmo_count <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
            err_count <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                cmd_write <= req_write;
                cmd_addr  <= req_addr;
                cmd_wdata <= req_wdata;
            end
            if (state == SETUP) begin
                tmo_count <= '0;
            end else if (state == ACCESS && !pready && !done_tmo) begin
                tmo_count <= tmo_count + 1'b1;
            end
            if (done_ok || done_tmo) begin
                rsp_valid <= 1'b1;
                rsp_write <= cmd_write;
                rsp_err   <= done_tmo;
                rsp_rdata <= (done_ok && !cmd_write) ? prdata : '0;
                txn_count <= txn_count + 16'd1;
                if (done_tmo && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdr_apb_master.sv
// Self-checking bench for sdr_apb_master, built with an 8-cycle timeout.
// A transfer-level model (active flag, age in cycles since SETUP) predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_sdr_apb_master;

    localparam int TMO = 8;

    logic        pclk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [15:0] txn_count;
    logic [7:0]  err_count;
    logic        pselect;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_active;
    int          m_age;
    bit          m_write;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    bit          m_rsp_valid;
    bit          m_rsp_write;
    logic [15:0] m_rsp_rdata;
    bit          m_rsp_err;
    logic [15:0] m_txn;
    int          m_err;
    bit          m_accept;

    sdr_apb_master #(
        .TIMEOUT_CYCLES(TMO),
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy),
        .txn_count(txn_count),
        .err_count(err_count),
        .pselect(pselect),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every output compared against the model for the current cycle.
    task automatic checkOutput();
        logic exp_ready;
        exp_ready = !preset && (!m_active || (m_age > 0 && pready));
        checkVal("req_ready", req_ready, exp_ready);
        checkVal("pselect", pselect, m_active);
        checkVal("penable", penable, m_active && m_age > 0);
        checkVal("busy", busy, m_active);
        checkVal("pwrite", pwrite, m_active ? m_write : 1'b0);
        checkVal("paddr", paddr, m_active ? m_addr : 16'h0);
        checkVal("pwdata", pwdata, m_active ? m_wdata : 16'h0);
        checkVal("rsp_valid", rsp_valid, m_rsp_valid);
        checkVal("rsp_write", rsp_write, m_rsp_write);
        checkVal("rsp_rdata", rsp_rdata, m_rsp_rdata);
        checkVal("rsp_err", rsp_err, m_rsp_err);
        checkVal("txn_count", txn_count, m_txn);
        checkVal("err_count", err_count, m_err);
    endtask

    task automatic takeCommand();
        m_active = 1;
        m_age    = 0;
        m_write  = req_write;
        m_addr   = req_addr;
        m_wdata  = req_wdata;
        m_accept = 1;
    endtask

    task automatic respond(input bit err);
        m_rsp_valid = 1;
        m_rsp_write = m_write;
        m_rsp_err   = err;
        m_rsp_rdata = (!err && !m_write) ? prdata : 16'h0;
        m_txn       = m_txn + 16'd1;
        if (err && m_err < 255) m_err++;
    endtask

    // One clock edge of the transfer-level model.
    task automatic modelStep();
        m_accept = 0;
        if (preset) begin
            m_active    = 0;
            m_age       = 0;
            m_rsp_valid = 0;
            m_rsp_write = 0;
            m_rsp_rdata = 0;
            m_rsp_err   = 0;
            m_txn       = 0;
            m_err       = 0;
        end else begin
            m_rsp_valid = 0;
            if (!m_active) begin
                if (req_valid) takeCommand();
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (pready) begin
                respond(0);
                if (req_valid) takeCommand();
                else m_active = 0;
            end else if (m_age == TMO) begin
                respond(1);
                m_active = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), compare, clock.
    task automatic applyStimulus(input logic v, input logic w, input logic [15:0] a,
                                 input logic [15:0] d, input logic [15:0] rd,
                                 input logic rdy, input logic rst);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        prdata    = rd;
        pready    = rdy;
        preset    = rst;
        #1;
        checkOutput();
        @(posedge pclk);
        modelStep();
        @(negedge pclk);
    endtask

    initial begin
        int pen_cnt;
        int sel_cnt;
        int rsp_cnt;
        int last_rsp;
        int idx;
        int thresh;

        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        prdata = 0; pready = 0; preset = 1;
        m_active = 0; m_age = 0; m_write = 0; m_addr = 0; m_wdata = 0;
        m_rsp_valid = 0; m_rsp_write = 0; m_rsp_rdata = 0; m_rsp_err = 0;
        m_txn = 0; m_err = 0; m_accept = 0;

        @(negedge pclk);
        @(negedge pclk);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 16'h1111, 0, 0, 1, 1);
        checkVal("reset_req_ready", req_ready, 0);
        checkVal("reset_pselect", pselect, 0);
        checkVal("reset_txn", txn_count, 0);
        preset = 0;
        req_valid = 0;
        #1;
        checkVal("ready_after_reset", req_ready, 1);
        @(negedge pclk);

        // Single write, pready in the first ACCESS cycle
        applyStimulus(1, 1, 16'h0010, 16'hA5A5, 0, 0, 0);
        checkVal("wr_setup_psel", pselect, 1);
        checkVal("wr_setup_pen", penable, 0);
        checkVal("wr_setup_addr", paddr, 16'h0010);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkVal("wr_access_pen", penable, 1);
        checkVal("wr_access_addr", paddr, 16'h0010);
        checkVal("wr_access_data", pwdata, 16'hA5A5);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkVal("wr_rsp_valid", rsp_valid, 1);
        checkVal("wr_rsp_err", rsp_err, 0);
        checkVal("wr_rsp_rdata", rsp_rdata, 0);
        checkVal("wr_txn", txn_count, 1);

        // Read with three wait states
        applyStimulus(1, 0, 16'h0020, 0, 0, 0, 0);
        pen_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 16'h1234, (i == 4), 0);
            if (penable) pen_cnt++;
        end
        checkVal("rd_pen_cycles", pen_cnt, 4);
        checkVal("rd_rsp_valid", rsp_valid, 1);
        checkVal("rd_rsp_rdata", rsp_rdata, 16'h1234);
        checkVal("rd_rsp_write", rsp_write, 0);

        // Back-to-back writes with req_valid held high
        idx = 0; sel_cnt = 0; rsp_cnt = 0; last_rsp = -1;
        for (int j = 0; j < 14; j++) begin
            applyStimulus(idx < 4, 1, 16'(idx), 16'hB000 + 16'(idx), 0, 1, 0);
            if (m_accept) idx++;
            if (pselect) sel_cnt++;
            if (rsp_valid) begin
                if (last_rsp >= 0) checkVal("b2b_gap", j - last_rsp, 2);
                last_rsp = j;
                rsp_cnt++;
            end
        end
        checkVal("b2b_rsp_count", rsp_cnt, 4);
        checkVal("b2b_psel_cycles", sel_cnt, 8);
        checkVal("b2b_txn", txn_count, 6);

        // Timeout with pready held low
        applyStimulus(1, 1, 16'h0030, 16'h5555, 0, 0, 0);
        pen_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 16'hFFFF, 0, 0);
            if (penable) pen_cnt++;
            if (rsp_valid) break;
        end
        checkVal("tmo_pen_cycles", pen_cnt, 8);
        checkVal("tmo_rsp_valid", rsp_valid, 1);
        checkVal("tmo_rsp_err", rsp_err, 1);
        checkVal("tmo_rsp_rdata", rsp_rdata, 0);
        checkVal("tmo_err_count", err_count, 1);
        checkVal("tmo_busy", busy, 0);
        checkVal("tmo_txn", txn_count, 7);

        // pready arrives in the final ACCESS cycle
        applyStimulus(1, 0, 16'h0040, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkVal("coin_pen", penable, 1);
        applyStimulus(0, 0, 0, 0, 16'hBEEF, 1, 0);
        checkVal("coin_rsp_valid", rsp_valid, 1);
        checkVal("coin_rsp_err", rsp_err, 0);
        checkVal("coin_rsp_rdata", rsp_rdata, 16'hBEEF);
        checkVal("coin_err_count", err_count, 1);

        // Reset in the middle of ACCESS
        applyStimulus(1, 1, 16'h0050, 16'h7777, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkVal("rst_mid_pen", penable, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("rst_mid_psel", pselect, 0);
        checkVal("rst_mid_rsp", rsp_valid, 0);
        checkVal("rst_mid_txn", txn_count, 0);
        checkVal("rst_mid_err", err_count, 0);
        preset = 0;
        #1;
        checkVal("rst_mid_ready", req_ready, 1);
        @(negedge pclk);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkVal("rst_mid_no_rsp", rsp_valid, 0);
        checkVal("rst_mid_busy", busy, 0);

        // Randomized traffic with varying pready density and rare resets
        thresh = 5;
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 0) begin
                case ($urandom_range(0, 3))
                    0: thresh = 0;
                    1: thresh = 3;
                    2: thresh = 7;
                    default: thresh = 10;
                endcase
            end
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1),
                          16'($urandom), 16'($urandom), 16'($urandom),
                          $urandom_range(0, 9) < thresh,
                          $urandom_range(0, 149) == 0);
        end

        // Drive enough timeouts to saturate the error counter
        for (int k = 0; k < 270; k++) begin
            applyStimulus(1, 1, 16'(k), 16'(k), 0, 0, 0);
            for (int i = 0; i < 14; i++) begin
                applyStimulus(0, 0, 0, 0, 0, 0, 0);
                if (m_rsp_valid) break;
            end
        end
        checkVal("err_saturated", err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
